siso_xfer_ctrl: RTL
===================

# siso_xfer_ctrl

Sequencing controller for the serial-in/serial-out shift chain (`SISO`). It accepts a parallel word over a valid/ready handshake and drives it bit-serially onto the chain's `si` input, one bit per clock. It then samples the chain's `so` output after the chain latency and reassembles the returned bits into a parallel word, presented over a second valid/ready handshake. It sits between a parallel producer/consumer and a free-running `SISO` instance, which shifts every clock and has no enable.

## Interface
- `WIDTH`, 8, bits per transferred word; must be ≥ 1.
- `DEPTH`, 4, number of flops in the attached SISO chain, i.e. `so` equals `si` delayed `DEPTH` cycles; must be ≥ 1.
- `MSB_FIRST`, 1, 1: bit `WIDTH-1` is shifted first; 0: bit 0 is shifted first.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  WIDTH  word to send.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  high in IDLE only.
- `si`  out  1  registered serial bit to the SISO `si` input.
- `so`  in  1  serial bit from the SISO `so` output.
- `out_data`  out  WIDTH  reassembled word, registered.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts `out_data`.
- `busy`  out  1  high in SHIFT, FLUSH and DONE.
- `err`  out  1  loopback mismatch flag (see Configuration).

## Operation
- FSM states: IDLE, SHIFT, FLUSH, DONE. Reset state is IDLE.
- IDLE: `in_ready`=1 and `si`=0. When `in_valid` & `in_ready` are both high at an edge, latch `in_data` into the send register, clear the counter, and go to SHIFT.
- SHIFT: `si` carries the next bit of the send register each cycle, in the order set by `MSB_FIRST`. After `WIDTH` bits have been driven, go to FLUSH.
- FLUSH: `si`=0 while the remaining bits drain out of the chain.
- Capture runs in parallel with SHIFT and FLUSH. The bit driven on `si` in cycle n is sampled from `so` at the edge ending cycle n+`DEPTH`. Each sample is placed in the same bit position the bit was sent from, so `out_data` equals `in_data` through a transparent chain.
- After the last capture, update `out_data` and go to DONE.
- DONE: `out_valid`=1, and `out_data` is held stable until `out_ready`. On the handshake, return to IDLE.
- `in_valid` is ignored outside IDLE. There is no overlap between words.
- Counter: one up-counter of `$clog2(WIDTH+DEPTH+1)` bits. It is cleared on accept and counts to `WIDTH+DEPTH-1`; there is no wrap within a transfer.
- Reset values: `in_ready`=1 (state IDLE), `si`=0, `out_data`=0, `out_valid`=0, `busy`=0, `err`=0. Handshakes are not honoured while `rst` is high.
- Reset asserted mid-transfer: the word is aborted immediately and nothing is output for it. The external chain may still hold stale bits, but these are never captured, because capture only runs in SHIFT and FLUSH.

## Timing
- Accept at edge a. `si` holds send bit k during cycle a+k, for k = 0…WIDTH-1.
- Capture of bit k occurs at edge a+k+DEPTH+1.
- `out_valid` rises at edge a+WIDTH+DEPTH, giving a latency of WIDTH+DEPTH cycles (12 with the defaults).
- Next accept is possible no earlier than one cycle after the `out_ready` handshake. Minimum period is WIDTH+DEPTH+2 cycles with `out_ready` held high.
- `out_ready` high on the same edge that DONE is entered is not a handshake: `out_valid` is visible for at least one cycle.

## Configuration
- Macro: `SISO_XFER_CTRL_LOOPBACK_CHK_EN`.
- Defined: when entering DONE, compare the captured word with the sent word. `err` is a sticky flag, set on mismatch and cleared only by `rst`.
- Undefined: the comparator and sticky register are absent, and `err` is tied to 0.

## Structure
- Package `siso_xfer_pkg` holds the FSM state enum typedef `siso_xfer_state_t` and the counter-width function/constant.
- One natural sub-module, `siso_bit_cnt`: the clear/enable up-counter with a terminal-count output, which selects both the send index and the capture index.
- Bench pairs the block with an existing `SISO` instance of `DEPTH` flops.

## Test plan
- Reset, then send 0xA5 with `out_ready`=1 → `si` sequence 1,0,1,0,0,1,0,1; `out_valid` 12 cycles after accept; `out_data`=0xA5; `err`=0.
- `MSB_FIRST`=0, send 0x01 → `si` is high only in the first SHIFT cycle; `out_data`=0x01.
- Hold `out_ready`=0 for 5 cycles in DONE → `out_valid` and `out_data` are stable; `in_ready`=0; `in_valid` pulses are ignored; after `out_ready` rises, the next word is accepted one cycle later.
- Back-to-back words 0xFF then 0x00 with `in_valid` held high → two outputs 0xFF and 0x00, with no residue from the first word in the second.
- Assert `rst` at cycle 3 of SHIFT → all outputs are at reset values within the same cycle; the next word 0x3C returns exactly 0x3C.
- With the macro defined, force `so`=0 while sending 0x80 → `out_data`=0x00; `err`=1, and it stays high until `rst`.

Source files
------------

// File: rtl/siso_xfer_pkg.sv
// siso_xfer_pkg
// Shared definitions for the SISO transfer controller:
//   - siso_xfer_state_t : FSM state encoding (IDLE, SHIFT, FLUSH, DONE)
//   - cnt_width()       : width of the transfer counter, which must reach
//                         WIDTH+DEPTH-1 without wrapping
package siso_xfer_pkg;

    typedef enum logic [1:0] {
        XFER_IDLE  = 2'd0,
        XFER_SHIFT = 2'd1,
        XFER_FLUSH = 2'd2,
        XFER_DONE  = 2'd3
    } siso_xfer_state_t;

    function automatic int cnt_width(input int width, input int depth);
        return $clog2(width + depth + 1);
    endfunction

endpackage

// File: rtl/siso_bit_cnt.sv
// siso_bit_cnt
// Clear/enable up-counter shared by the send and capture paths of the
// transfer controller. It saturates at TERM, so it never wraps inside a
// transfer.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear to 0 (has priority over en)
//   en       : count enable
//   cnt      : current count
//   tc       : high while cnt == TERM
module siso_bit_cnt #(
    parameter int CW   = 4,
    parameter int TERM = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    localparam logic [CW-1:0] TERM_V = CW'(TERM);

    assign tc = (cnt == TERM_V);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/siso_xfer_ctrl.sv
// siso_xfer_ctrl
// Sends a parallel word bit-serially into a free-running SISO chain of
// DEPTH flops and reassembles the word returning on the chain output.
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid is never taken back by this block once raised, and
// ready is a pure function of the FSM state.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_data/in_valid     : word to send and its valid
//   in_ready             : high only in IDLE
//   si                   : registered serial bit to the chain input
//   so                   : serial bit from the chain output
//   out_data/out_valid   : reassembled word (registered) and its valid
//   out_ready            : consumer accepts out_data
//   busy                 : high in SHIFT, FLUSH and DONE
//   err                  : sticky loopback mismatch flag
// Optional feature: define SISO_XFER_CTRL_LOOPBACK_CHK_EN to compare the
// returned word with the sent word; otherwise err is tied low.
module siso_xfer_ctrl
    import siso_xfer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             si,
    input  logic             so,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             err
);

    localparam int CW = cnt_width(WIDTH, DEPTH);

    localparam logic [1:0] ST_IDLE  = XFER_IDLE;
    localparam logic [1:0] ST_SHIFT = XFER_SHIFT;
    localparam logic [1:0] ST_FLUSH = XFER_FLUSH;
    localparam logic [1:0] ST_DONE  = XFER_DONE;

    // Count value during the last SHIFT cycle and the first capture cycle.
    localparam logic [CW-1:0] LAST_SEND = CW'(WIDTH - 1);
    localparam logic [CW-1:0] FIRST_CAP = CW'(DEPTH);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             cnt_tc;
    logic             accept;
    logic             running;
    logic             cap_en;
    logic             first_bit;
    logic             next_bit;
    logic [WIDTH-1:0] send_reg;
    logic [WIDTH-1:0] cap_reg;
    logic [WIDTH-1:0] cap_nxt;

    // Word bit position of the k-th serial bit; capture uses the same map so
    // every returned bit lands where it was sent from.
    function automatic int bit_pos(input int k);
        return MSB_FIRST ? (WIDTH - 1 - k) : k;
    endfunction

    assign accept    = (state == ST_IDLE) && in_valid;
    assign running   = (state == ST_SHIFT) || (state == ST_FLUSH);
    // The bit driven at count c returns on so while the count is c+DEPTH.
    assign cap_en    = running && (cnt >= FIRST_CAP);
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);

    siso_bit_cnt #(
        .CW   (CW),
        .TERM (WIDTH + DEPTH - 1)
    ) u_bit_cnt (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .en  (running),
        .cnt (cnt),
        .tc  (cnt_tc)
    );

    // Bit selection by comparison loop keeps every index in range even when
    // the count-derived position falls outside the word.
    always_comb begin
        first_bit = 1'b0;
        next_bit  = 1'b0;
        cap_nxt   = cap_reg;
        for (int i = 0; i < WIDTH; i++) begin
            if (i == bit_pos(0)) begin
                first_bit = in_data[i];
            end
            if (i == bit_pos(int'(cnt) + 1)) begin
                next_bit = send_reg[i];
            end
            if (cap_en && (i == bit_pos(int'(cnt) - DEPTH))) begin
                cap_nxt[i] = so;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            si       <= 1'b0;
            send_reg <= '0;
            cap_reg  <= '0;
            out_data <= '0;
        end else begin
            si <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        send_reg <= in_data;
                        cap_reg  <= '0;
                        si       <= first_bit;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    cap_reg <= cap_nxt;
                    if (cnt == LAST_SEND) begin
                        state <= ST_FLUSH;
                    end else begin
                        si <= next_bit;
                    end
                end
                ST_FLUSH: begin
                    cap_reg <= cap_nxt;
                    // Last capture always happens here since DEPTH >= 1.
                    if (cnt_tc) begin
                        out_data <= cap_nxt;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SISO_XFER_CTRL_LOOPBACK_CHK_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((state == ST_FLUSH) && cnt_tc && (cap_nxt != send_reg)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
